// File: rtl/lxa_8bit_adder.sv
`default_nettype none
// ============================================================================
//  Module      : lxa_8bit_adder
//  Description : Registered lower-XOR approximate adder. The low APPROX_BITS
//                of the sum are a carry-free XOR; the upper part is an exact
//                add, seeded by the generate of the top approximate bit.
//  Revision    : 1.0  initial release
// ============================================================================
module lxa_8bit_adder #(
    parameter int WIDTH       = 8,
    parameter int APPROX_BITS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH:0]   sum,
    output logic             out_valid,
    output logic             err
);

    localparam int K_BITS  = APPROX_BITS;
    localparam int UP_BITS = WIDTH - APPROX_BITS;

    generate
        if (APPROX_BITS < 1 || APPROX_BITS > WIDTH - 1) begin : g_bad_approx_bits
            $error("lxa_8bit_adder: APPROX_BITS must lie in 1..WIDTH-1");
        end
    endgenerate

    logic [K_BITS-1:0]  w_s_low;
    logic               w_carry;
    logic [UP_BITS:0]   w_s_up;
    logic [WIDTH:0]     w_s_approx;
    logic [WIDTH:0]     w_s_exact;
    logic               w_err_next;

    logic [WIDTH:0]     sum_d;
    logic [WIDTH:0]     sum_q;
    logic               err_d;
    logic               err_q;
    logic               out_valid_d;
    logic               out_valid_q;

    // The upper add is exact; only the carry chain across the low bits is cut,
    // with the top low bit's generate standing in for the lost carry.
    always_comb begin
        w_s_low    = a[K_BITS-1:0] ^ b[K_BITS-1:0];
        w_carry    = a[K_BITS-1] & b[K_BITS-1];
        w_s_up     = {1'b0, a[WIDTH-1:K_BITS]}
                   + {1'b0, b[WIDTH-1:K_BITS]}
                   + {{UP_BITS{1'b0}}, w_carry};
        w_s_approx = {w_s_up, w_s_low};
        w_s_exact  = {1'b0, a} + {1'b0, b};
        w_err_next = (w_s_approx != w_s_exact);
    end

    always_comb begin
        sum_d       = sum_q;
        err_d       = err_q;
        out_valid_d = in_valid;
        if (in_valid) begin
            sum_d = w_s_approx;
            err_d = w_err_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q       <= '0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            sum_q       <= sum_d;
            err_q       <= err_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign sum       = sum_q;
    assign err       = err_q;
    assign out_valid = out_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_lxa_8bit_adder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lxa_8bit_adder
//  Description : Self-checking bench for lxa_8bit_adder (WIDTH=8, K=4):
//                directed cases, valid pipeline, async reset, full sweep.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_lxa_8bit_adder;

    typedef struct {
        logic [8:0] sum;
        logic       err;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [7:0] a;
    logic [7:0] b;
    logic [8:0] sum;
    logic       out_valid;
    logic       err;

    exp_t       sb_q[$];
    int         n_chk;
    int         n_pass;
    logic [8:0] last_sum;
    logic       last_err;

    lxa_8bit_adder #(
        .WIDTH       (8),
        .APPROX_BITS (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .sum       (sum),
        .out_valid (out_valid),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [8:0] lxa_model(input logic [7:0] x, input logic [7:0] y);
        logic [3:0] lo;
        logic [4:0] hi;
        lo = x[3:0] ^ y[3:0];
        hi = {1'b0, x[7:4]} + {1'b0, y[7:4]} + {4'b0, x[3] & y[3]};
        return {hi, lo};
    endfunction

    // Drive one cycle of stimulus; results are popped from the scoreboard
    // when out_valid shows up, otherwise the outputs must hold.
    task automatic step(input logic v, input logic [7:0] xa, input logic [7:0] xb,
                        input logic [8:0] exp_sum, input logic exp_err);
        exp_t e;
        in_valid = v;
        a        = xa;
        b        = xb;
        if (v) begin
            e.sum = exp_sum;
            e.err = exp_err;
            sb_q.push_back(e);
        end
        @(posedge clk);
        #1;
        chk("out_valid", {31'b0, out_valid}, {31'b0, v});
        if (out_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("sb_empty", 32'd0, 32'd1);
            end else begin
                e = sb_q.pop_front();
                chk("sum", {23'b0, sum}, {23'b0, e.sum});
                chk("err", {31'b0, err}, {31'b0, e.err});
                last_sum = e.sum;
                last_err = e.err;
            end
        end else begin
            chk("sum_hold", {23'b0, sum}, {23'b0, last_sum});
            chk("err_hold", {31'b0, err}, {31'b0, last_err});
        end
    endtask

    initial begin
        int   e_val;
        int   n_err;
        longint ae;
        longint se;
        real  mae, mse, rmse, er, mep;

        n_chk    = 0;
        n_pass   = 0;
        last_sum = '0;
        last_err = 1'b0;
        rst      = 1'b1;
        in_valid = 1'b0;
        a        = '0;
        b        = '0;

        #2;
        chk("rst_sum", {23'b0, sum}, 32'd0);
        chk("rst_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_err", {31'b0, err}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        step(1'b1, 8'h30, 8'h40, 9'h070, 1'b0);
        step(1'b1, 8'h0F, 8'h01, 9'h00E, 1'b1);
        step(1'b1, 8'hFF, 8'hFF, 9'h1F0, 1'b1);
        step(1'b1, 8'h08, 8'h08, 9'h010, 1'b0);
        step(1'b1, 8'h80, 8'h80, 9'h100, 1'b0);

        step(1'b1, 8'h12, 8'h34, 9'h046, 1'b0);
        step(1'b1, 8'h55, 8'h2A, 9'h07F, 1'b0);
        step(1'b0, 8'hAA, 8'hAA, 9'h000, 1'b0);
        step(1'b1, 8'h0C, 8'h0C, 9'h010, 1'b1);

        // Asynchronous reset between edges with out_valid high, then an
        // in-flight operand that must be discarded while reset is held.
        rst = 1'b1;
        #1;
        chk("arst_sum", {23'b0, sum}, 32'd0);
        chk("arst_valid", {31'b0, out_valid}, 32'd0);
        chk("arst_err", {31'b0, err}, 32'd0);
        in_valid = 1'b1;
        a        = 8'hFF;
        b        = 8'hFF;
        @(posedge clk);
        #1;
        chk("inflight_sum", {23'b0, sum}, 32'd0);
        chk("inflight_valid", {31'b0, out_valid}, 32'd0);
        rst      = 1'b0;
        last_sum = '0;
        last_err = 1'b0;
        #2;
        step(1'b1, 8'h30, 8'h40, 9'h070, 1'b0);

        n_err = 0;
        ae    = 0;
        se    = 0;
        for (int ia = 0; ia < 256; ia++) begin
            for (int ib = 0; ib < 256; ib++) begin
                logic [7:0] xa;
                logic [7:0] xb;
                logic [8:0] ms;
                xa = ia[7:0];
                xb = ib[7:0];
                ms = lxa_model(xa, xb);
                step(1'b1, xa, xb, ms, (ms != ({1'b0, xa} + {1'b0, xb})));
                e_val = int'(sum) - (ia + ib);
                chk("err_range", {31'b0, (e_val >= -14 && e_val <= 0)}, 32'd1);
                chk("err_flag", {31'b0, err}, {31'b0, (e_val != 0)});
                if ((xa[2:0] & xb[2:0]) == 3'b000)
                    chk("err_free", {31'b0, err}, 32'd0);
                if (e_val != 0) n_err++;
                ae += (e_val < 0) ? -e_val : e_val;
                se += e_val * e_val;
            end
        end
        in_valid = 1'b0;

        er   = real'(n_err) / 65536.0;
        mae  = real'(ae) / 65536.0;
        mse  = real'(se) / 65536.0;
        rmse = $sqrt(mse);
        mep  = mae / 510.0 * 100.0;
        $display("metrics: ER=%f AE=%0d MAE=%f MSE=%f RMSE=%f MEP=%f%%", er, ae, mae, mse, rmse, mep);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
